// File: rtl/quad_encoder_emulator.sv
// Quadrature encoder emulator: turns detent/press commands into A/B/PB
// waveforms that drive the rotational encoder decoder under test.
//
// Ports:
//   clk, rst      single clock, synchronous active-high reset
//   cmd_valid     command offered; accepted on cmd_valid & cmd_ready
//   cmd_ready     emulator idle (registered)
//   cmd_dir       1 = CW, 0 = CCW
//   cmd_steps     detents to emit (0 = none)
//   cmd_pb        00 none, 01 short press, 10 long press, 11 none
//   cmd_dwell     cycles per quadrature phase (0 behaves as 1)
//   A, B          quadrature phases, rest at 00
//   PB            pushbutton, active high
//   busy          command in progress
//   done          one-cycle pulse in the first cycle back in IDLE
//   pos           detent position, modulo 2^POS_W
module quad_encoder_emulator #(
    parameter int POS_W     = 4,
    parameter int DWELL_W   = 16,
    parameter int SHORT_CYC = 1000,
    parameter int LONG_CYC  = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_dir,
    input  logic [POS_W-1:0]   cmd_steps,
    input  logic [1:0]         cmd_pb,
    input  logic [DWELL_W-1:0] cmd_dwell,
    output logic               A,
    output logic               B,
    output logic               PB,
    output logic               busy,
    output logic               done,
    output logic [POS_W-1:0]   pos
);

    localparam int PW = $clog2(LONG_CYC + 1);
    localparam logic [PW-1:0] C_SHORT_M1 = PW'(SHORT_CYC - 1);
    localparam logic [PW-1:0] C_LONG_M1  = PW'(LONG_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROT,
        S_SETTLE,
        S_PRESS,
        S_GAP
    } state_t;

    state_t             r_state;
    logic               r_dir;
    logic [POS_W-1:0]   r_steps;
    logic [1:0]         r_pb;
    logic [DWELL_W-1:0] r_dwell_m1;
    logic [DWELL_W-1:0] r_dcnt;
    logic [PW-1:0]      r_pcnt;
    logic [1:0]         r_phase;
    logic               r_a;
    logic               r_b;
    logic               r_pb_out;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic [POS_W-1:0]   r_pos;

    logic [DWELL_W-1:0] w_dwell_m1;
    logic               w_dwell_end;
    logic [1:0]         w_phase_nxt;
    logic               w_cw_a;
    logic               w_cw_b;
    logic               w_a_nxt;
    logic               w_b_nxt;
    logic               w_press_req;
    logic [PW-1:0]      w_press_last;

    // A zero dwell is stretched to one cycle per phase.
    assign w_dwell_m1  = (cmd_dwell == '0) ? '0 : cmd_dwell - DWELL_W'(1);
    assign w_dwell_end = (r_dcnt == r_dwell_m1);

    // Phase index 0..3 maps to CW levels 00,10,11,01 (Gray order, so
    // only one of A/B moves per step); CCW swaps the roles of A and B.
    assign w_phase_nxt = r_phase + 2'd1;
    assign w_cw_a      = w_phase_nxt[1] ^ w_phase_nxt[0];
    assign w_cw_b      = w_phase_nxt[1];
    assign w_a_nxt     = r_dir ? w_cw_a : w_cw_b;
    assign w_b_nxt     = r_dir ? w_cw_b : w_cw_a;

    // 01 and 10 request a press; 11 is ignored like 00.
    assign w_press_req  = r_pb[1] ^ r_pb[0];
    assign w_press_last = r_pb[1] ? C_LONG_M1 : C_SHORT_M1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_dir      <= 1'b0;
            r_steps    <= '0;
            r_pb       <= 2'b00;
            r_dwell_m1 <= '0;
            r_dcnt     <= '0;
            r_pcnt     <= '0;
            r_phase    <= 2'd0;
            r_a        <= 1'b0;
            r_b        <= 1'b0;
            r_pb_out   <= 1'b0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pos      <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (cmd_valid && r_ready) begin
                        r_ready    <= 1'b0;
                        r_busy     <= 1'b1;
                        r_dir      <= cmd_dir;
                        r_steps    <= cmd_steps;
                        r_pb       <= cmd_pb;
                        r_dwell_m1 <= w_dwell_m1;
                        r_dcnt     <= '0;
                        r_phase    <= 2'd0;
                        r_state    <= (cmd_steps != '0) ? S_ROT : S_SETTLE;
                    end
                end
                S_ROT: begin
                    if (w_dwell_end) begin
                        r_dcnt  <= '0;
                        r_phase <= w_phase_nxt;
                        r_a     <= w_a_nxt;
                        r_b     <= w_b_nxt;
                        // Phase 3 -> 0 returns A/B to rest: detent complete.
                        if (r_phase == 2'd3) begin
                            r_pos   <= r_dir ? r_pos + POS_W'(1)
                                             : r_pos - POS_W'(1);
                            r_steps <= r_steps - POS_W'(1);
                            if (r_steps == POS_W'(1)) begin
                                r_state <= S_SETTLE;
                            end
                        end
                    end else begin
                        r_dcnt <= r_dcnt + DWELL_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (w_dwell_end) begin
                        r_dcnt <= '0;
                        if (w_press_req) begin
                            r_pcnt   <= '0;
                            r_pb_out <= 1'b1;
                            r_state  <= S_PRESS;
                        end else begin
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_dcnt <= r_dcnt + DWELL_W'(1);
                    end
                end
                S_PRESS: begin
                    if (r_pcnt == w_press_last) begin
                        r_pb_out <= 1'b0;
                        r_dcnt   <= '0;
                        r_state  <= S_GAP;
                    end else begin
                        r_pcnt <= r_pcnt + PW'(1);
                    end
                end
                S_GAP: begin
                    if (w_dwell_end) begin
                        r_dcnt  <= '0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_dcnt <= r_dcnt + DWELL_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign A         = r_a;
    assign B         = r_b;
    assign PB        = r_pb_out;
    assign pos       = r_pos;

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Testbench for quad_encoder_emulator: directed command scenarios and
// random commands, each output cycle compared to a waveform model.
module tb_quad_encoder_emulator;

    localparam int POS_W   = 4;
    localparam int DWELL_W = 16;
    localparam int SHORT   = 4;
    localparam int LONG    = 12;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_dir;
    logic [POS_W-1:0]   cmd_steps;
    logic [1:0]         cmd_pb;
    logic [DWELL_W-1:0] cmd_dwell;
    logic               A;
    logic               B;
    logic               PB;
    logic               busy;
    logic               done;
    logic [POS_W-1:0]   pos;

    int checks = 0;
    int errors = 0;
    int mpos   = 0;

    always #5 clk = ~clk;

    quad_encoder_emulator #(
        .POS_W    (POS_W),
        .DWELL_W  (DWELL_W),
        .SHORT_CYC(SHORT),
        .LONG_CYC (LONG)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_dir  (cmd_dir),
        .cmd_steps(cmd_steps),
        .cmd_pb   (cmd_pb),
        .cmd_dwell(cmd_dwell),
        .A        (A),
        .B        (B),
        .PB       (PB),
        .busy     (busy),
        .done     (done),
        .pos      (pos)
    );

    // Output vector layout: {A, B, PB, done, cmd_ready, busy, pos}
    function automatic logic [9:0] obs();
        return {A, B, PB, done, cmd_ready, busy, pos};
    endfunction

    function automatic logic [9:0] idle_vec(int p);
        logic [3:0] pv;
        pv = 4'(p);
        return {5'b00001, 1'b0, pv};
    endfunction

    function automatic int press_len(logic [1:0] pb);
        if (pb == 2'b01) return SHORT;
        if (pb == 2'b10) return LONG;
        return 0;
    endfunction

    function automatic int done_at(int n, int d, logic [1:0] pb);
        int pl;
        pl = press_len(pb);
        return 4 * n * d + d + ((pl > 0) ? pl + d : 0);
    endfunction

    // Expected outputs at +k for a command accepted with position p0.
    function automatic logic [9:0] model(int k, bit dir, int n,
                                         logic [1:0] pb, int d, int p0);
        int         rot_end;
        int         settle_end;
        int         pl;
        int         dk;
        int         det;
        int         ph;
        logic [1:0] ab;
        logic       pbv;
        logic       fin;
        logic [3:0] pv;
        rot_end    = 4 * n * d;
        settle_end = rot_end + d;
        pl         = press_len(pb);
        dk         = done_at(n, d, pb);
        ab         = 2'b00;
        if (k < rot_end) begin
            det = k / (4 * d);
            ph  = (k / d) % 4;
            case (ph)
                1: ab = 2'b10;
                2: ab = 2'b11;
                3: ab = 2'b01;
                default: ab = 2'b00;
            endcase
            if (!dir) ab = {ab[0], ab[1]};
        end else begin
            det = n;
        end
        pv  = 4'(p0 + (dir ? det : -det));
        pbv = (pl > 0) && (k >= settle_end) && (k < settle_end + pl);
        fin = (k == dk);
        return {ab, pbv, fin, fin, ~fin, pv};
    endfunction

    task automatic check(string tag, int k, logic [9:0] o, logic [9:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s +%0d observed=%b expected=%b", tag, k, o, e);
        end
    endtask

    task automatic run_cmd(string tag, bit dir, int n, logic [1:0] pb,
                           int dwell, bit hold);
        int d;
        int dk;
        int p0;
        d  = (dwell == 0) ? 1 : dwell;
        dk = done_at(n, d, pb);
        p0 = mpos;
        cmd_dir   = dir;
        cmd_steps = 4'(n);
        cmd_pb    = pb;
        cmd_dwell = 16'(dwell);
        cmd_valid = 1'b1;
        check({tag, "_ready"}, -1, {9'd0, cmd_ready}, 10'd1);
        @(posedge clk);
        #1;
        if (hold) begin
            cmd_dir   = 1'($urandom);
            cmd_steps = 4'($urandom);
            cmd_pb    = 2'($urandom);
            cmd_dwell = 16'($urandom);
        end else begin
            cmd_valid = 1'b0;
        end
        for (int k = 0; k <= dk; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            check(tag, k, obs(), model(k, dir, n, pb, d, p0));
        end
        mpos = (p0 + (dir ? n : -n)) & 15;
    endtask

    initial begin
        bit         hold;
        bit         rdir;
        int         rn;
        int         rd;
        int         gap;
        logic [1:0] rpb;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_steps = '0;
        cmd_pb    = 2'b00;
        cmd_dwell = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 0, obs(), idle_vec(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset", 1, obs(), idle_vec(0));

        run_cmd("ccw2_d1", 1'b0, 2, 2'b00, 1, 1'b0);
        run_cmd("cw1_d2", 1'b1, 1, 2'b00, 2, 1'b0);
        run_cmd("wrap_long", 1'b1, 1, 2'b10, 1, 1'b0);
        run_cmd("short_only", 1'b0, 0, 2'b01, 3, 1'b0);
        run_cmd("pb11_none", 1'b1, 1, 2'b11, 1, 1'b0);

        run_cmd("hold_first", 1'b1, 1, 2'b01, 2, 1'b1);
        run_cmd("hold_second", 1'b0, 1, 2'b00, 0, 1'b0);

        cmd_dir   = 1'b1;
        cmd_steps = 4'd1;
        cmd_pb    = 2'b00;
        cmd_dwell = 16'd2;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("abort_run", 0, obs(), model(0, 1'b1, 1, 2'b00, 2, mpos));
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            check("abort_run", k, obs(), model(k, 1'b1, 1, 2'b00, 2, mpos));
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        mpos = 0;
        check("abort_reset", 4, obs(), idle_vec(0));
        for (int k = 5; k <= 12; k++) begin
            @(posedge clk);
            #1;
            check("abort_quiet", k, obs(), idle_vec(0));
        end

        run_cmd("cw1_d2_fresh", 1'b1, 1, 2'b00, 2, 1'b0);

        hold = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rdir = 1'($urandom_range(0, 1));
            rn   = $urandom_range(0, 4);
            rpb  = 2'($urandom_range(0, 3));
            rd   = $urandom_range(0, 3);
            hold = (i < 19) && ($urandom_range(0, 3) == 0);
            run_cmd("random", rdir, rn, rpb, rd, hold);
            if (!hold) begin
                gap = $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk);
                    #1;
                    check("random_idle", g, obs(), idle_vec(mpos));
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
